mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory port arbiter: both request/response
// channels plus the single-port synchronous RAM side.
interface mem_port_arbiter_if;
    logic        req0_valid;
    logic        req0_we;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        rsp1_err;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM;
// one transaction in flight, out-of-range addresses answered with err=1.
module mem_port_arbiter #(
    parameter int unsigned RAM_BASE  = 150500,
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

    // 33-bit bounds so RAM_BASE + RAM_WORDS can never wrap around
    localparam logic [32:0] RANGE_LO  = 33'(RAM_BASE);
    localparam logic [32:0] RANGE_END = 33'(RAM_BASE) + 33'(RAM_WORDS);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant_id;
    logic        grant_any;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        mem_we;
    logic        finish;
    logic [31:0] rsp_data;

    logic        lat_we;
    logic        lat_id;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        in_range;

    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp0_rdata;
    logic [31:0] rsp1_rdata;
    logic        rsp0_err;
    logic        rsp1_err;

    assign in_range = ({1'b0, lat_addr} >= RANGE_LO) && ({1'b0, lat_addr} < RANGE_END);

    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = bus.req1_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = lat_we ? IDLE : READ;
            READ:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready0   = 1'b0;
        ready1   = 1'b0;
        mem_we   = 1'b0;
        finish   = 1'b0;
        rsp_data = '0;
        if (state == IDLE && !rst && grant_any) begin
            ready0 = ~grant_id;
            ready1 = grant_id;
        end
        if (state == ACCESS) begin
            mem_we = lat_we & in_range;
            finish = lat_we;
        end
        if (state == READ) begin
            finish   = 1'b1;
            rsp_data = in_range ? bus.mem_rdata : '0;
        end
    end

    assign accept = ready0 | ready1;

    // The latched request doubles as the RAM address/data hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (accept) begin
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_we     <= grant_id ? bus.req1_we    : bus.req0_we;
            lat_addr   <= grant_id ? bus.req1_addr  : bus.req0_addr;
            lat_wdata  <= grant_id ? bus.req1_wdata : bus.req0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= finish && !lat_id;
            rsp1_valid <= finish && lat_id;
            rsp0_rdata <= (finish && !lat_id) ? rsp_data : '0;
            rsp1_rdata <= (finish && lat_id) ? rsp_data : '0;
            rsp0_err   <= finish && !lat_id && !in_range;
            rsp1_err   <= finish && lat_id && !in_range;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp0_rdata = rsp0_rdata;
    assign bus.rsp1_rdata = rsp1_rdata;
    assign bus.rsp0_err   = rsp0_err;
    assign bus.rsp1_err   = rsp1_err;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small RAM model on the memory side and
// hand-computed response timing for each requester transaction.
module tb_mem_port_arbiter;

    localparam int unsigned RAM_BASE  = 150500;
    localparam int unsigned RAM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .RAM_BASE  (RAM_BASE),
        .RAM_WORDS (RAM_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Read-only RAM contents; out-of-range reads return garbage the DUT must mask
    function automatic logic [31:0] ramRead(input logic [31:0] addr);
        if (addr == 32'd150500)      return 32'd45;
        else if (addr == 32'd151523) return 32'd77;
        else if (addr >= 32'(RAM_BASE) && addr < 32'(RAM_BASE + RAM_WORDS)) return 32'd0;
        else                         return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) bus.mem_rdata <= ramRead(bus.mem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 1) begin
            bus.req1_valid = valid;
            bus.req1_we    = we;
            bus.req1_addr  = addr;
            bus.req1_wdata = wdata;
        end else begin
            bus.req0_valid = valid;
            bus.req0_we    = we;
            bus.req0_addr  = addr;
            bus.req0_wdata = wdata;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    function automatic logic [31:0] readyOf(input int id);
        return 32'(id == 1 ? bus.req1_ready : bus.req0_ready);
    endfunction

    function automatic logic [31:0] validOf(input int id);
        return 32'(id == 1 ? bus.rsp1_valid : bus.rsp0_valid);
    endfunction

    function automatic logic [31:0] rdataOf(input int id);
        return id == 1 ? bus.rsp1_rdata : bus.rsp0_rdata;
    endfunction

    function automatic logic [31:0] errOf(input int id);
        return 32'(id == 1 ? bus.rsp1_err : bus.rsp0_err);
    endfunction

    task automatic doWrite(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_in_range, input string tag);
        cycle(); applyStimulus(id, 1'b1, 1'b1, addr, wdata); #1;
        checkOutput({tag, "_ready"}, readyOf(id), 32'd1);
        checkOutput({tag, "_other_ready"}, readyOf(1 - id), 32'd0);
        cycle(); applyStimulus(id, 1'b0, 1'b0, '0, '0); #1;
        checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'(exp_in_range));
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, addr);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cycle(); #1;
        checkOutput({tag, "_mem_we_drop"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_rsp_valid"}, validOf(id), 32'd1);
        checkOutput({tag, "_rsp_err"}, errOf(id), 32'(!exp_in_range));
        checkOutput({tag, "_rsp_rdata"}, rdataOf(id), 32'd0);
        checkOutput({tag, "_other_rsp"}, validOf(1 - id), 32'd0);
    endtask

    // poke raises the other requester's valid while busy and withdraws it before IDLE
    task automatic doRead(input int id, input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic poke, input string tag);
        cycle(); applyStimulus(id, 1'b1, 1'b0, addr, '0); #1;
        checkOutput({tag, "_ready"}, readyOf(id), 32'd1);
        cycle(); applyStimulus(id, 1'b0, 1'b0, '0, '0);
        if (poke) applyStimulus(1 - id, 1'b1, 1'b0, 32'd150502, '0);
        #1;
        checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, addr);
        if (poke) checkOutput({tag, "_poke_ready_access"}, readyOf(1 - id), 32'd0);
        cycle(); #1;
        checkOutput({tag, "_read_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_read_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_early_rsp"}, validOf(id), 32'd0);
        if (poke) checkOutput({tag, "_poke_ready_read"}, readyOf(1 - id), 32'd0);
        cycle(); applyStimulus(1 - id, 1'b0, 1'b0, '0, '0); #1;
        checkOutput({tag, "_rsp_valid"}, validOf(id), 32'd1);
        checkOutput({tag, "_rsp_rdata"}, rdataOf(id), exp_rdata);
        checkOutput({tag, "_rsp_err"}, errOf(id), 32'(exp_err));
        checkOutput({tag, "_other_rsp"}, validOf(1 - id), 32'd0);
    endtask

    initial begin
        int          i0;
        int          i1;
        int          k;
        int          we_cnt;
        logic        gid;
        logic [31:0] pend_wdata;

        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 32'd150501, 32'd9);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle();
        #1;
        checkOutput("reset_ready0", 32'(bus.req0_ready), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        cycle(); rst = 1'b0; applyStimulus(0, 1'b0, 1'b0, '0, '0);

        $display("[TB] single write and reads");
        doWrite(0, 32'd150501, 32'd33, 1'b1, "wr_inrange");
        cycle(); #1;
        checkOutput("wr_rsp_one_cycle", 32'(bus.rsp0_valid), 32'd0);
        doRead(0, 32'd150500, 32'd45, 1'b0, 1'b1, "rd_inrange");
        cycle(); #1;
        checkOutput("withdrawn_no_effect", 32'(bus.busy), 32'd0);
        doRead(1, 32'd500, 32'd0, 1'b1, 1'b0, "rd_oor");
        doRead(0, 32'd151523, 32'd77, 1'b0, 1'b0, "rd_top");
        doRead(0, 32'd151524, 32'd0, 1'b1, 1'b0, "rd_above");
        doWrite(1, 32'd151524, 32'd5, 1'b0, "wr_above");

        $display("[TB] contention from reset");
        cycle(); rst = 1'b1; #1;
        checkOutput("contend_reset_busy", 32'(bus.busy), 32'd0);
        cycle(); rst = 1'b0;
        i0 = 0; i1 = 0; k = 0; we_cnt = 0; pend_wdata = '0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            applyStimulus(0, i0 < 4, 1'b1, 32'd150600 + 32'(i0), 32'd100 + 32'(i0));
            applyStimulus(1, i1 < 4, 1'b1, 32'd150700 + 32'(i1), 32'd200 + 32'(i1));
            #1;
            if (bus.mem_we) begin
                we_cnt++;
                checkOutput("contend_wdata", bus.mem_wdata, pend_wdata);
            end
            if (bus.req0_ready || bus.req1_ready) begin
                gid = bus.req1_ready;
                checkOutput("contend_single_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                checkOutput("contend_grant", 32'(gid), 32'(k % 2));
                pend_wdata = gid ? 32'd200 + 32'(i1) : 32'd100 + 32'(i0);
                if (gid) i1++;
                else     i0++;
                k++;
            end
        end
        checkOutput("contend_grants", 32'(k), 32'd8);
        checkOutput("contend_we_pulses", 32'(we_cnt), 32'd8);

        $display("[TB] reset during write access");
        cycle(); applyStimulus(0, 1'b1, 1'b1, 32'd150510, 32'd222); #1;
        checkOutput("mid_rst_ready", 32'(bus.req0_ready), 32'd1);
        cycle(); applyStimulus(0, 1'b0, 1'b0, '0, '0); #1;
        checkOutput("mid_rst_we_before", 32'(bus.mem_we), 32'd1);
        checkOutput("mid_rst_wdata", bus.mem_wdata, 32'd222);
        #2; rst = 1'b1; #1;
        checkOutput("mid_rst_we_async", 32'(bus.mem_we), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        cycle(); #1;
        checkOutput("mid_rst_no_rsp", 32'(bus.rsp0_valid), 32'd0);
        cycle(); rst = 1'b0; #1;
        checkOutput("mid_rst_no_rsp_after", 32'(bus.rsp0_valid), 32'd0);
        cycle();
        applyStimulus(0, 1'b1, 1'b1, 32'd150520, 32'd1);
        applyStimulus(1, 1'b1, 1'b1, 32'd150521, 32'd2);
        #1;
        checkOutput("post_rst_grant0", 32'(bus.req0_ready), 32'd1);
        checkOutput("post_rst_no_grant1", 32'(bus.req1_ready), 32'd0);
        cycle();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
